core_bus_arbiter: RTL and testbench
===================================

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 Parameter DBUS_MAX_RUN, default 4, meaning: maximum consecutive dbus grants while ibus is pending. The SHALL range is 1..15.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 ibus_avalon_req  input  avalon_req_t  core instruction-bus request (read, address, byte_enable used; write ignored).
REQ-005 ibus_avalon_resp  output  avalon_resp_t  instruction-bus response (readdata, waitrequest).
REQ-006 dbus_avalon_req  input  avalon_req_t  core data-bus request (read, write, address, writedata, byte_enable).
REQ-007 dbus_avalon_resp  output  avalon_resp_t  data-bus response.
REQ-008 mem_avalon_req  output  avalon_req_t  single shared port toward memory.
REQ-009 mem_avalon_resp  input  avalon_resp_t  shared port response; readdata has fixed latency 1 after an accepted read.

Function
REQ-010 Request terms: a master requests when read|write is 1. A transfer is accepted when mem_avalon_req.read|write=1 and mem_avalon_resp.waitrequest=0 in the same cycle.
REQ-011 Grant state gnt_q SHALL be one of NONE, IBUS, DBUS.
REQ-012 In NONE, or on the cycle a transfer is accepted, the grant for the current cycle SHALL be selected combinationally as follows:
- dbus wins if requesting and run_cnt < DBUS_MAX_RUN;
- otherwise ibus wins if requesting;
- otherwise dbus wins if requesting;
- otherwise NONE.
REQ-013 Once a master is granted and its transfer is not accepted (waitrequest=1), the grant SHALL be locked. Re-arbitration SHALL NOT occur until acceptance. Mid-transfer preemption is forbidden.
REQ-014 After acceptance, gnt_q SHALL return to NONE unless another request is granted in the same cycle per REQ-012. Back-to-back transfers SHALL be possible with zero idle cycles.
REQ-015 mem_avalon_req SHALL equal the granted master's request fields. With no grant, all mem_avalon_req fields SHALL be 0.
REQ-016 The granted master's waitrequest SHALL equal mem_avalon_resp.waitrequest.
REQ-017 A requesting, non-granted master SHALL see waitrequest=1. A non-requesting master SHALL see waitrequest=0.
REQ-018 run_cnt (4 bits) behaviour:
- increments on each accepted dbus transfer while ibus is requesting, saturating at DBUS_MAX_RUN;
- clears on any accepted ibus transfer;
- clears in any cycle ibus is not requesting.
REQ-019 rd_owner_q (2 bits) SHALL register the owner of each accepted read; it is NONE for writes and for idle cycles.
REQ-020 In the cycle after an accepted read, mem_avalon_resp.readdata SHALL be routed to the owner's readdata. The non-owner's readdata SHALL be 0.
REQ-021 Arbitration SHALL NOT stall on a pending read response. A new transfer MAY be accepted in the same cycle a response returns.
REQ-022 ibus write=1 SHALL never be forwarded. Only ibus read is passed.
REQ-023 Simultaneous first requests from both masters with run_cnt=0 SHALL grant dbus.
REQ-024 The block SHALL add no latency to the request path (combinational pass-through) and exactly 0 extra cycles to read data.

Reset
REQ-025 While rst=1, the following SHALL hold:
- gnt_q=NONE, run_cnt=0, rd_owner_q=NONE;
- all mem_avalon_req fields = 0;
- both response readdata = 0;
- both response waitrequest = 1 if the master is requesting, 0 otherwise.
REQ-026 Reset asserted mid-transfer SHALL drop the grant. Any read response due in the following cycle SHALL be discarded, with readdata=0 to both masters.
REQ-027 The first cycle after rst deasserts SHALL arbitrate as from NONE.

Verification
REQ-028 Single ibus read, address 0x100, memory waitrequest=0, readdata 0xDEADBEEF next cycle. Required: mem read=1, address 0x100 in cycle 0; ibus readdata=0xDEADBEEF in cycle 1; dbus readdata=0.
REQ-029 Both masters request in the same cycle: ibus read 0x0, dbus write 0x2000 data 0x55. Required:
- cycle 0: dbus granted, mem write=1, ibus waitrequest=1;
- cycle 1: ibus read accepted.
REQ-030 Memory holds waitrequest=1 for 3 cycles on a dbus read of 0x3000. Required:
- grant locked 4 cycles;
- mem address stable at 0x3000;
- ibus request stays blocked;
- readdata delivered to dbus one cycle after acceptance.
REQ-031 DBUS_MAX_RUN=4, dbus issues 6 back-to-back reads while ibus requests continuously. Required: grant order D,D,D,D,I,D,D.
REQ-032 rst=1 asserted in the cycle a dbus read is accepted. Required: the next cycle shows dbus readdata=0 and ibus readdata=0; gnt_q=NONE and run_cnt=0.
REQ-033 ibus asserts write=1 with address 0x40. Required: mem write stays 0 for the whole test.

Source files
------------

// File: rtl/core_bus_arbiter.sv
// Two-master (instruction/data) Avalon arbiter onto one shared memory port.
// Data bus has priority but yields to a waiting instruction bus after DBUS_MAX_RUN grants.
package core_bus_arbiter_pkg;
   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [31:0] writedata;
      logic [3:0]  byte_enable;
   } avalon_req_t;

   typedef struct packed {
      logic [31:0] readdata;
      logic        waitrequest;
   } avalon_resp_t;
endpackage

module core_bus_arbiter
   import core_bus_arbiter_pkg::*;
#(
   parameter int unsigned DBUS_MAX_RUN = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  avalon_req_t  ibus_avalon_req,
   output avalon_resp_t ibus_avalon_resp,
   input  avalon_req_t  dbus_avalon_req,
   output avalon_resp_t dbus_avalon_resp,
   output avalon_req_t  mem_avalon_req,
   input  avalon_resp_t mem_avalon_resp
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IBUS = 2'd1,
      GNT_DBUS = 2'd2
   } gnt_e;

   localparam logic [3:0] MAX_RUN = 4'(DBUS_MAX_RUN);

   gnt_e       gnt_q;
   gnt_e       gnt_cur;
   gnt_e       rd_owner_q;
   logic [3:0] run_cnt;
   logic       ibus_rqst;
   logic       dbus_rqst;
   logic       mem_active;
   logic       accepted;

   // An instruction-bus write is not a request at all: it is never forwarded.
   assign ibus_rqst = ibus_avalon_req.read;
   assign dbus_rqst = dbus_avalon_req.read | dbus_avalon_req.write;

   always_comb begin
      gnt_cur = gnt_q;
      if (rst) begin
         gnt_cur = GNT_NONE;
      end else if (gnt_q == GNT_NONE) begin
         if (dbus_rqst && (run_cnt < MAX_RUN)) gnt_cur = GNT_DBUS;
         else if (ibus_rqst)                   gnt_cur = GNT_IBUS;
         else if (dbus_rqst)                   gnt_cur = GNT_DBUS;
         else                                  gnt_cur = GNT_NONE;
      end
   end

   always_comb begin
      mem_avalon_req = '0;
      case (gnt_cur)
         GNT_IBUS: begin
            mem_avalon_req       = ibus_avalon_req;
            mem_avalon_req.write = 1'b0;
         end
         GNT_DBUS: mem_avalon_req = dbus_avalon_req;
         default:  mem_avalon_req = '0;
      endcase
   end

   assign mem_active = mem_avalon_req.read | mem_avalon_req.write;
   assign accepted   = mem_active & ~mem_avalon_resp.waitrequest;

   always_comb begin
      ibus_avalon_resp = '0;
      dbus_avalon_resp = '0;
      ibus_avalon_resp.waitrequest = (gnt_cur == GNT_IBUS) ? mem_avalon_resp.waitrequest : ibus_rqst;
      dbus_avalon_resp.waitrequest = (gnt_cur == GNT_DBUS) ? mem_avalon_resp.waitrequest : dbus_rqst;
      if (!rst && rd_owner_q == GNT_IBUS) ibus_avalon_resp.readdata = mem_avalon_resp.readdata;
      if (!rst && rd_owner_q == GNT_DBUS) dbus_avalon_resp.readdata = mem_avalon_resp.readdata;
   end

   // gnt_q only holds a stalled grant; after acceptance the next cycle arbitrates afresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q      <= GNT_NONE;
         rd_owner_q <= GNT_NONE;
         run_cnt    <= '0;
      end else begin
         gnt_q      <= (mem_active && mem_avalon_resp.waitrequest) ? gnt_cur : GNT_NONE;
         rd_owner_q <= (accepted && mem_avalon_req.read) ? gnt_cur : GNT_NONE;
         if (!ibus_rqst || (accepted && gnt_cur == GNT_IBUS))
            run_cnt <= '0;
         else if (accepted && gnt_cur == GNT_DBUS && run_cnt < MAX_RUN)
            run_cnt <= run_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: directed scenarios then random traffic,
// each cycle's expected outputs come from a transaction-level reference model.
module tb_core_bus_arbiter;
   import core_bus_arbiter_pkg::*;

   localparam int MAX_RUN = 4;

   typedef struct packed {
      avalon_req_t  mem;
      avalon_resp_t ib;
      avalon_resp_t db;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   avalon_req_t  ibus_avalon_req = '0;
   avalon_resp_t ibus_avalon_resp;
   avalon_req_t  dbus_avalon_req = '0;
   avalon_resp_t dbus_avalon_resp;
   avalon_req_t  mem_avalon_req;
   avalon_resp_t mem_avalon_resp = '0;

   core_bus_arbiter #(.DBUS_MAX_RUN(MAX_RUN)) dut (
      .clk              (clk),
      .rst              (rst),
      .ibus_avalon_req  (ibus_avalon_req),
      .ibus_avalon_resp (ibus_avalon_resp),
      .dbus_avalon_req  (dbus_avalon_req),
      .dbus_avalon_resp (dbus_avalon_resp),
      .mem_avalon_req   (mem_avalon_req),
      .mem_avalon_resp  (mem_avalon_resp)
   );

   always #5 clk = ~clk;

   exp_t        expq[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic        log_en = 1'b0;
   string       grant_log = "";

   // Reference model: who holds the bus, how many data grants in a row, who gets read data.
   int          m_holder = 0;   // 0 none, 1 ibus, 2 dbus
   int          m_streak = 0;
   int          m_rd_owner = 0;
   logic        i_acc, d_acc;
   avalon_req_t ib = '0, db = '0;

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         vectors++;
         if (mem_avalon_req !== e.mem) begin
            miscompares++;
            $display("FAIL mem_req got %h want %h", mem_avalon_req, e.mem);
         end
         vectors++;
         if (ibus_avalon_resp !== e.ib) begin
            miscompares++;
            $display("FAIL ibus_resp got %h want %h", ibus_avalon_resp, e.ib);
         end
         vectors++;
         if (dbus_avalon_resp !== e.db) begin
            miscompares++;
            $display("FAIL dbus_resp got %h want %h", dbus_avalon_resp, e.db);
         end
      end
      if (log_en && mem_avalon_req.read && !mem_avalon_resp.waitrequest && !rst)
         grant_log = {grant_log, (mem_avalon_req.address[12] ? "D" : "I")};
   end

   task automatic cycle(input logic r, input logic mw, input logic [31:0] rd);
      exp_t e;
      int   w;
      logic ireq, dreq, acc;
      @(posedge clk);
      #1;
      rst = r;
      ibus_avalon_req = ib;
      dbus_avalon_req = db;
      mem_avalon_resp.readdata = rd;
      mem_avalon_resp.waitrequest = mw;
      ireq = ib.read;
      dreq = db.read | db.write;
      e = '0;
      i_acc = 1'b0;
      d_acc = 1'b0;
      if (r) begin
         e.ib.waitrequest = ireq;
         e.db.waitrequest = dreq;
         m_holder = 0;
         m_streak = 0;
         m_rd_owner = 0;
      end else begin
         w = m_holder;
         if (w == 0) begin
            if (dreq && m_streak < MAX_RUN) w = 2;
            else if (ireq)                  w = 1;
            else if (dreq)                  w = 2;
         end
         if (w == 1) begin
            e.mem = ib;
            e.mem.write = 1'b0;
         end else if (w == 2) begin
            e.mem = db;
         end
         e.ib.waitrequest = (w == 1) ? mw : ireq;
         e.db.waitrequest = (w == 2) ? mw : dreq;
         e.ib.readdata = (m_rd_owner == 1) ? rd : 32'h0;
         e.db.readdata = (m_rd_owner == 2) ? rd : 32'h0;
         acc = (w != 0) && !mw;
         i_acc = acc && (w == 1);
         d_acc = acc && (w == 2);
         m_rd_owner = (acc && e.mem.read) ? w : 0;
         m_holder = (w != 0 && mw) ? w : 0;
         if (!ireq || i_acc) m_streak = 0;
         else if (d_acc && m_streak < MAX_RUN) m_streak++;
      end
      expq.push_back(e);
   endtask

   task automatic run_plain(input int n);
      for (int k = 0; k < n; k++) begin
         cycle(1'b0, 1'b0, $urandom);
         if (i_acc) ib = '0;
         if (d_acc) db = '0;
      end
   endtask

   function automatic avalon_req_t mk(input logic r, input logic w, input logic [31:0] a,
                                      input logic [31:0] d);
      avalon_req_t q;
      q = '{read: r, write: w, address: a, writedata: d, byte_enable: 4'hF};
      return q;
   endfunction

   initial begin
      // reset with ibus requesting: waitrequest reflects the request
      ib = mk(1, 0, 32'h10, 0);
      cycle(1'b1, 1'b0, $urandom);
      cycle(1'b1, 1'b0, $urandom);
      ib = '0;
      cycle(1'b1, 1'b0, $urandom);

      // single ibus read with fixed-latency data
      ib = mk(1, 0, 32'h100, 0);
      cycle(1'b0, 1'b0, $urandom);
      ib = '0;
      cycle(1'b0, 1'b0, 32'hDEADBEEF);

      // simultaneous first requests: dbus first, ibus next cycle
      ib = mk(1, 0, 32'h0, 0);
      db = mk(0, 1, 32'h2000, 32'h55);
      run_plain(3);

      // memory stalls a dbus read for 3 cycles; grant stays locked
      ib = mk(1, 0, 32'h0, 0);
      db = mk(1, 0, 32'h3000, 0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, $urandom);
      cycle(1'b0, 1'b0, $urandom);
      if (d_acc) db = '0;
      run_plain(3);
      ib = '0;
      db = '0;
      run_plain(2);

      // run limit: six back-to-back dbus reads against a continuous ibus read stream
      begin
         int left = 6;
         log_en = 1'b1;
         grant_log = "";
         ib = mk(1, 0, 32'h0, 0);
         for (int k = 0; k < 20 && grant_log.len() < 7; k++) begin
            if (!db.read && left > 0) begin
               db = mk(1, 0, 32'h1000 + 32'(left), 0);
               left--;
            end
            cycle(1'b0, 1'b0, $urandom);
            if (i_acc) ib = mk(1, 0, 32'h4, 0);
            if (d_acc) db = '0;
            @(negedge clk);
         end
         log_en = 1'b0;
         vectors++;
         if (grant_log.substr(0, 6) != "DDDDIDD") begin
            miscompares++;
            $display("FAIL grant_order got %s want DDDDIDD", grant_log);
         end
         ib = '0;
         db = '0;
         run_plain(2);
      end

      // reset right after an accepted dbus read, and over a pending read
      db = mk(1, 0, 32'h5000, 0);
      cycle(1'b0, 1'b0, $urandom);
      if (d_acc) db = '0;
      cycle(1'b1, 1'b0, 32'hCAFEF00D);
      db = mk(1, 0, 32'h5004, 0);
      ib = mk(1, 0, 32'h8, 0);
      cycle(1'b1, 1'b0, $urandom);
      cycle(1'b1, 1'b0, $urandom);
      run_plain(4);

      // ibus write is never forwarded
      ib = mk(0, 1, 32'h40, 32'h1234);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, $urandom);
      ib = '0;

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 3), $urandom);
         if (i_acc || !ib.read) begin
            ib = '0;
            case ($urandom_range(0, 4))
               0, 1:    ib = mk(1, 0, $urandom & 32'hFFF, 0);
               2:       ib = mk(0, 1, $urandom, $urandom);
               default: ib = '0;
            endcase
            ib.byte_enable = 4'($urandom);
         end
         if (d_acc || !(db.read || db.write)) begin
            case ($urandom_range(0, 4))
               0, 1:    db = mk(1, 0, $urandom, 0);
               2:       db = mk(0, 1, $urandom, $urandom);
               3:       db = mk(1, 0, 32'h1000, 0);
               default: db = '0;
            endcase
            db.byte_enable = 4'($urandom);
         end
      end

      for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
      #1;
      if (expq.size() > 0) begin
         miscompares++;
         $display("FAIL drain left %0d want 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
